// File: rtl/t07_spitft_pkg.sv
// Shared types, offsets and payload helpers for the TFT SPI write window.
package t07_spitft_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BIT_W  = 5;
  localparam int unsigned NB_W   = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    HOLD,
    DONE
  } state_t;

  localparam logic [WORD_W-1:0] OFF_CMD    = 32'd4;
  localparam logic [WORD_W-1:0] OFF_DATA8  = 32'd8;
  localparam logic [WORD_W-1:0] OFF_DATA16 = 32'd12;
  localparam logic [WORD_W-1:0] OFF_DATA32 = 32'd16;
  localparam logic [WORD_W-1:0] OFF_CTRL   = 32'd20;

  // Bytes to serialise for a window offset; zero means no SPI activity.
  function automatic logic [NB_W-1:0] byte_count(input logic [WORD_W-1:0] off);
    case (off)
      OFF_CMD, OFF_DATA8: return NB_W'(1);
      OFF_DATA16:         return NB_W'(2);
      OFF_DATA32:         return NB_W'(4);
      default:            return NB_W'(0);
    endcase
  endfunction

  // Left-align the payload so the first byte to send sits in the top bits.
  function automatic logic [WORD_W-1:0] align_word(input logic [NB_W-1:0] nbytes,
                                                   input logic [WORD_W-1:0] data);
    case (nbytes)
      NB_W'(1): return {data[7:0], 24'h000000};
      NB_W'(2): return {data[15:0], 16'h0000};
      default:  return data;
    endcase
  endfunction

endpackage

// File: rtl/t07_spi_byte_tx.sv
// Mode-0 SPI serialiser: clock divider, sclk generation, 32-bit shift register, bit counter.
module t07_spi_byte_tx
  import t07_spitft_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  input  logic [NB_W-1:0]   nbytes,
  input  logic              div_en,
  input  logic              shift_en,
  output logic              tick_c,
  output logic              shift_done_c,
  output logic              sclk,
  output logic              mosi
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0]  div_cnt;
  logic [WORD_W-1:0] shreg;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BIT_W-1:0]  last_bit;

  assign tick_c       = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign shift_done_c = shift_en & tick_c & sclk & (bit_cnt == last_bit);
  assign mosi         = shreg[WORD_W-1];

  // sclk toggles each half-period; data advances on the falling transition.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      div_cnt  <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      last_bit <= '0;
      sclk     <= 1'b0;
    end else if (load) begin
      div_cnt  <= '0;
      shreg    <= word;
      bit_cnt  <= '0;
      last_bit <= BIT_W'({nbytes, 3'b000} - 6'd1);
      sclk     <= 1'b0;
    end else begin
      if (div_en) div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
      if (shift_en && tick_c) begin
        sclk <= ~sclk;
        if (sclk) begin
          shreg   <= {shreg[WORD_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + BIT_W'(1);
        end
      end else if (!shift_en) begin
        sclk <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/t07_spitft.sv
// MMIO write responder for the TFT window: decodes requests, frames SPI transfers, owns TFT reset.
module t07_spitft
  import t07_spitft_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 2,
  parameter logic [31:0] BASE_ADDR = 32'd1792
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        wi_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] data_in,
  output logic        ack,
  output logic        tft_sclk,
  output logic        tft_mosi,
  output logic        tft_cs_n,
  output logic        tft_dc,
  output logic        tft_rst_n
);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] off_c;
  logic [WORD_W-1:0] word_c;
  logic [NB_W-1:0]   nbytes_c;
  logic              load_c, tick_c, shift_done_c, div_en_c, shift_en_c;
  logic              dc_d, rst_n_d, cs_n_d;

  assign off_c      = addr_in - BASE_ADDR;
  assign nbytes_c   = byte_count(off_c);
  assign word_c     = align_word(nbytes_c, data_in);
  assign div_en_c   = (state_q == LOAD) | (state_q == SHIFT) | (state_q == HOLD);
  assign shift_en_c = (state_q == SHIFT);

  // Busy handshake: only the DONE cycle (or an idle bus) releases the CPU.
  assign ack = nrst & (((state_q == IDLE) & wi_in) | ((state_q != IDLE) & (state_q != DONE)));

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= IDLE;
      tft_cs_n  <= 1'b1;
      tft_dc    <= 1'b0;
      tft_rst_n <= 1'b0;
    end else begin
      state_q   <= state_d;
      tft_cs_n  <= cs_n_d;
      tft_dc    <= dc_d;
      tft_rst_n <= rst_n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    dc_d    = tft_dc;
    rst_n_d = tft_rst_n;
    case (state_q)
      IDLE: begin
        if (wi_in) begin
          if (nbytes_c != NB_W'(0)) begin
            load_c  = 1'b1;
            dc_d    = (off_c != OFF_CMD);
            state_d = LOAD;
          end else begin
            if (off_c == OFF_CTRL) rst_n_d = data_in[0];
            state_d = DONE;
          end
        end
      end
      LOAD:    if (tick_c) state_d = SHIFT;
      SHIFT:   if (shift_done_c) state_d = HOLD;
      HOLD:    if (tick_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cs_n_d = !((state_d == LOAD) || (state_d == SHIFT) || (state_d == HOLD));
  end

  t07_spi_byte_tx #(
    .CLK_DIV(CLK_DIV)
  ) u_tx (
    .clk         (clk),
    .nrst        (nrst),
    .load        (load_c),
    .word        (word_c),
    .nbytes      (nbytes_c),
    .div_en      (div_en_c),
    .shift_en    (shift_en_c),
    .tick_c      (tick_c),
    .shift_done_c(shift_done_c),
    .sclk        (tft_sclk),
    .mosi        (tft_mosi)
  );

endmodule

// File: tb/tb_t07_spitft.sv
// Scoreboard bench for t07_spitft: expected transfer summaries queued at request, compared at DONE.
module tb_t07_spitft;

  localparam int unsigned CLK_DIV = 2;
  localparam logic [31:0] BASE    = 32'd1792;

  logic        clk = 1'b0;
  logic        nrst;
  logic        wi_in;
  logic [31:0] addr_in;
  logic [31:0] data_in;
  logic        ack, tft_sclk, tft_mosi, tft_cs_n, tft_dc, tft_rst_n;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    int          ack_cyc;
    int          cs_cyc;
    int          rises;
    logic [31:0] bits;
    logic        dc;
  } xfer_t;

  xfer_t sb[$];

  always #5 clk = ~clk;

  t07_spitft #(.CLK_DIV(CLK_DIV), .BASE_ADDR(BASE)) dut (
    .clk(clk), .nrst(nrst), .wi_in(wi_in), .addr_in(addr_in), .data_in(data_in),
    .ack(ack), .tft_sclk(tft_sclk), .tft_mosi(tft_mosi), .tft_cs_n(tft_cs_n),
    .tft_dc(tft_dc), .tft_rst_n(tft_rst_n)
  );

  // Expected bus behaviour of one request, from the address map and timing rules.
  function automatic xfer_t model(input logic [31:0] a, input logic [31:0] d);
    xfer_t e;
    int n;
    logic [31:0] off;
    off = a - BASE;
    case (off)
      32'd4, 32'd8: n = 1;
      32'd12:       n = 2;
      32'd16:       n = 4;
      default:      n = 0;
    endcase
    e.rises   = 8 * n;
    e.cs_cyc  = (n != 0) ? int'(CLK_DIV) * (2 + 16 * n) : 0;
    e.ack_cyc = 1 + e.cs_cyc;
    e.bits    = (n == 4) ? d : (n == 2) ? {16'h0, d[15:0]} : (n == 1) ? {24'h0, d[7:0]} : 32'h0;
    e.dc      = (n != 0) && (off != 32'd4);
    return e;
  endfunction

  // Issue one request and observe the bus until the DONE cycle (ack low) or timeout.
  task automatic run_req(input logic [31:0] a, input logic [31:0] d, input bit keep_wi,
                         output xfer_t got, output bit to);
    logic prev;
    got  = '0;
    to   = 1'b1;
    prev = 1'b0;
    @(negedge clk);
    wi_in = 1'b1; addr_in = a; data_in = d;
    for (int c = 0; c < 1000; c++) begin
      #1;
      if (ack) got.ack_cyc = got.ack_cyc + 1;
      if (!tft_cs_n) begin got.cs_cyc = got.cs_cyc + 1; got.dc = tft_dc; end
      if (tft_sclk && !prev) begin got.rises = got.rises + 1; got.bits = {got.bits[30:0], tft_mosi}; end
      prev = tft_sclk;
      if (!ack) begin to = 1'b0; break; end
      @(negedge clk);
      if (!keep_wi) begin wi_in = 1'b0; addr_in = BASE + 32'd16; data_in = ~d; end
    end
  endtask

  task automatic test_reset;
    nrst = 1'b0; wi_in = 1'b1; addr_in = BASE + 32'd4; data_in = 32'hFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({ack, tft_cs_n, tft_sclk, tft_rst_n, tft_dc, tft_mosi} !== 6'b010000) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d got ack/cs_n/sclk/rst_n/dc/mosi=%b want 010000", i,
                 {ack, tft_cs_n, tft_sclk, tft_rst_n, tft_dc, tft_mosi});
      end
    end
    @(negedge clk);
    nrst = 1'b1; wi_in = 1'b0;
    #1;
    checks++;
    if ({ack, tft_cs_n, tft_rst_n} !== 3'b010) begin
      errors++;
      $display("FAIL reset_release got ack/cs_n/rst_n=%b want 010", {ack, tft_cs_n, tft_rst_n});
    end
  endtask

  task automatic test_spi_writes;
    logic [31:0] addrs[4];
    logic [31:0] datas[4];
    xfer_t got, e;
    bit to;
    addrs = '{BASE + 32'd4, BASE + 32'd12, BASE + 32'd8, BASE + 32'd16};
    datas = '{32'h000000A5, 32'h0000F81F, $urandom, $urandom};
    for (int i = 0; i < 4; i++) begin
      sb.push_back(model(addrs[i], datas[i]));
      run_req(addrs[i], datas[i], 1'b0, got, to);
      e = sb.pop_front();
      checks++;
      if (to) begin errors++; $display("FAIL spi_timeout addr %0d got no DONE want DONE", addrs[i]); end
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL spi_xfer addr %0d got ack=%0d cs=%0d rises=%0d bits=%h dc=%b want ack=%0d cs=%0d rises=%0d bits=%h dc=%b",
                 addrs[i], got.ack_cyc, got.cs_cyc, got.rises, got.bits, got.dc,
                 e.ack_cyc, e.cs_cyc, e.rises, e.bits, e.dc);
      end
      @(negedge clk); #1;
      checks++;
      if ({ack, tft_cs_n, tft_sclk} !== 3'b010) begin
        errors++;
        $display("FAIL spi_idle_after addr %0d got ack/cs_n/sclk=%b want 010", addrs[i], {ack, tft_cs_n, tft_sclk});
      end
    end
  endtask

  task automatic test_ctrl;
    xfer_t got, e;
    bit to;
    for (int v = 1; v >= 0; v--) begin
      sb.push_back(model(BASE + 32'd20, 32'(v)));
      run_req(BASE + 32'd20, 32'(v), 1'b0, got, to);
      e = sb.pop_front();
      checks++;
      if (to || got !== e) begin
        errors++;
        $display("FAIL ctrl_xfer data %0d got ack=%0d cs=%0d rises=%0d to=%b want ack=%0d cs=%0d rises=%0d",
                 v, got.ack_cyc, got.cs_cyc, got.rises, to, e.ack_cyc, e.cs_cyc, e.rises);
      end
      checks++;
      if (tft_rst_n !== 1'(v)) begin
        errors++;
        $display("FAIL ctrl_rst_n got %b want %0d", tft_rst_n, v);
      end
    end
  endtask

  task automatic test_abort;
    xfer_t got, e;
    bit to;
    logic prev;
    int rises;
    prev = 1'b0; rises = 0;
    @(negedge clk);
    wi_in = 1'b1; addr_in = BASE + 32'd16; data_in = 32'h12345678;
    for (int c = 0; c < 400 && rises < 4; c++) begin
      #1;
      if (tft_sclk && !prev) rises++;
      prev = tft_sclk;
      if (rises < 4) begin @(negedge clk); wi_in = 1'b0; end
    end
    checks++;
    if (rises != 4) begin errors++; $display("FAIL abort_reach_bit3 got %0d rises want 4", rises); end
    @(negedge clk);
    nrst = 1'b0;
    #1;
    checks++;
    if ({ack, tft_cs_n} !== 2'b00) begin
      errors++;
      $display("FAIL abort_ack_comb got ack/cs_n=%b want 00", {ack, tft_cs_n});
    end
    @(negedge clk); #1;
    checks++;
    if ({ack, tft_cs_n, tft_sclk} !== 3'b010) begin
      errors++;
      $display("FAIL abort_edge got ack/cs_n/sclk=%b want 010", {ack, tft_cs_n, tft_sclk});
    end
    nrst = 1'b1;
    sb.push_back(model(BASE + 32'd4, 32'h0000003C));
    run_req(BASE + 32'd4, 32'h0000003C, 1'b0, got, to);
    e = sb.pop_front();
    checks++;
    if (to || got !== e) begin
      errors++;
      $display("FAIL abort_followup got ack=%0d cs=%0d rises=%0d bits=%h dc=%b to=%b want ack=%0d cs=%0d rises=%0d bits=%h dc=%b",
               got.ack_cyc, got.cs_cyc, got.rises, got.bits, got.dc, to,
               e.ack_cyc, e.cs_cyc, e.rises, e.bits, e.dc);
    end
  endtask

  task automatic test_back_to_back;
    xfer_t got, e;
    bit to;
    sb.push_back(model(BASE + 32'd8, 32'h000000C3));
    sb.push_back(model(BASE + 32'd8, 32'h0000005A));
    run_req(BASE + 32'd8, 32'h000000C3, 1'b1, got, to);
    for (int k = 0; k < 2; k++) begin
      e = sb.pop_front();
      checks++;
      if (to || got !== e) begin
        errors++;
        $display("FAIL b2b_xfer %0d got ack=%0d cs=%0d rises=%0d bits=%h dc=%b to=%b want ack=%0d cs=%0d rises=%0d bits=%h dc=%b",
                 k, got.ack_cyc, got.cs_cyc, got.rises, got.bits, got.dc, to,
                 e.ack_cyc, e.cs_cyc, e.rises, e.bits, e.dc);
      end
      if (k == 0) run_req(BASE + 32'd8, 32'h0000005A, 1'b0, got, to);
    end
  endtask

  task automatic test_unmapped;
    xfer_t got, e;
    bit to;
    logic rst_before;
    rst_before = tft_rst_n;
    sb.push_back(model(32'd1900, 32'hFFFFFFFF));
    run_req(32'd1900, 32'hFFFFFFFF, 1'b0, got, to);
    e = sb.pop_front();
    checks++;
    if (to || got !== e) begin
      errors++;
      $display("FAIL unmapped_xfer got ack=%0d cs=%0d rises=%0d to=%b want ack=%0d cs=%0d rises=%0d",
               got.ack_cyc, got.cs_cyc, got.rises, to, e.ack_cyc, e.cs_cyc, e.rises);
    end
    checks++;
    if (tft_rst_n !== rst_before) begin
      errors++;
      $display("FAIL unmapped_rst_n got %b want %b", tft_rst_n, rst_before);
    end
  endtask

  initial begin
    test_reset();
    test_spi_writes();
    test_ctrl();
    test_abort();
    test_back_to_back();
    test_unmapped();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
